// File: rtl/bist_march_ram.sv
// Single-port synchronous RAM with registered read and an embedded March C- BIST engine.
// A read-path XOR mask lets the fail path be exercised without a real defect.
module bist_march_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ERRC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] bist_fail_addr,
    output logic [2:0]        bist_fail_elem,
    output logic [ERRC_W-1:0] bist_err_cnt,
    input  logic              inj_en,
    input  logic [DATA_W-1:0] inj_mask
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_W0, S_RD, S_CHK, S_DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_elem;
    logic [DATA_W-1:0] r_rdq;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [2:0]        r_fail_elem;
    logic [ERRC_W-1:0] r_err_cnt;

    logic              w_idle;
    logic [DATA_W-1:0] w_inj;
    logic [DATA_W-1:0] w_exp;
    logic              w_mis;
    logic              w_down;
    logic              w_last;
    logic [2:0]        w_next_elem;
    logic              w_next_down;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_idle      = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_inj       = inj_en ? inj_mask : '0;
    // Elements 2 and 4 read back ones; 1, 3 and 5 read back zeros.
    assign w_exp       = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? '1 : '0;
    assign w_mis       = (r_rdq != w_exp);
    assign w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_last      = w_down ? (r_addr == '0) : (&r_addr);
    assign w_next_elem = r_elem + 3'd1;
    assign w_next_down = (w_next_elem == 3'd3) || (w_next_elem == 3'd4);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = addr;
        w_wdata = wr_data;
        if (w_idle) begin
            w_we = wr_en;
        end else if (r_state == S_W0) begin
            w_we    = 1'b1;
            w_waddr = r_addr;
            w_wdata = '0;
        end else if ((r_state == S_CHK) && (r_elem != 3'd5)) begin
            w_we    = 1'b1;
            w_waddr = r_addr;
            w_wdata = ~w_exp;
        end
    end

    // Array is deliberately not reset; reads in the FSM block see pre-write data.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_elem      <= '0;
            r_rdq       <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (rd_en) begin
                        r_rd_data  <= r_mem[addr] ^ w_inj;
                        r_rd_valid <= 1'b1;
                    end
                    if (bist_start) begin
                        r_state     <= S_W0;
                        r_addr      <= '0;
                        r_elem      <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_fail_addr <= '0;
                        r_fail_elem <= '0;
                        r_err_cnt   <= '0;
                    end
                end
                S_W0: begin
                    if (&r_addr) begin
                        r_state <= S_RD;
                        r_elem  <= 3'd1;
                        r_addr  <= '0;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                S_RD: begin
                    r_rdq   <= r_mem[r_addr] ^ w_inj;
                    r_state <= S_CHK;
                end
                S_CHK: begin
                    if (w_mis) begin
                        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERRC_W'(1);
                        if (!r_fail) begin
                            r_fail      <= 1'b1;
                            r_fail_addr <= r_addr;
                            r_fail_elem <= r_elem;
                        end
                    end
                    if (w_last) begin
                        if (r_elem == 3'd5) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_elem  <= w_next_elem;
                            r_addr  <= w_next_down ? '1 : '0;
                            r_state <= S_RD;
                        end
                    end else begin
                        r_addr  <= w_down ? (r_addr - ADDR_W'(1)) : (r_addr + ADDR_W'(1));
                        r_state <= S_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data        = r_rd_data;
    assign rd_valid       = r_rd_valid;
    assign bist_busy      = r_busy;
    assign bist_done      = r_done;
    assign bist_fail      = r_fail;
    assign bist_fail_addr = r_fail_addr;
    assign bist_fail_elem = r_fail_elem;
    assign bist_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_bist_march_ram.sv
// Randomised bench for bist_march_ram against a March C- reference model over a plain array.
module tb_bist_march_ram;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int ERRC_W = 8;
    localparam int DEPTH  = 16;
    localparam int RUN_CYC = 11 * DEPTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              bist_start;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_fail;
    logic [ADDR_W-1:0] bist_fail_addr;
    logic [2:0]        bist_fail_elem;
    logic [ERRC_W-1:0] bist_err_cnt;
    logic              inj_en;
    logic [DATA_W-1:0] inj_mask;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_m [DEPTH];
    logic [7:0] last_rd;

    bist_march_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERRC_W(ERRC_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
        .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
        .bist_fail(bist_fail), .bist_fail_addr(bist_fail_addr),
        .bist_fail_elem(bist_fail_elem), .bist_err_cnt(bist_err_cnt),
        .inj_en(inj_en), .inj_mask(inj_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rd_data"}, 32'(rd_data), 0);
        chk({tag, ".rd_valid"}, 32'(rd_valid), 0);
        chk({tag, ".busy"}, 32'(bist_busy), 0);
        chk({tag, ".done"}, 32'(bist_done), 0);
        chk({tag, ".fail"}, 32'(bist_fail), 0);
        chk({tag, ".faddr"}, 32'(bist_fail_addr), 0);
        chk({tag, ".felem"}, 32'(bist_fail_elem), 0);
        chk({tag, ".errcnt"}, 32'(bist_err_cnt), 0);
    endtask

    // One functional cycle; reads see the model array before this cycle's write.
    task automatic op(input bit we, input bit re, input logic [3:0] a, input logic [7:0] d,
                      input bit ie, input logic [7:0] im, input string tag);
        wr_en = we; rd_en = re; addr = a; wr_data = d; inj_en = ie; inj_mask = im;
        tick();
        if (re) last_rd = mem_m[a] ^ (ie ? im : 8'h00);
        if (we) mem_m[a] = d;
        wr_en = 0; rd_en = 0; inj_en = 0; inj_mask = 0;
        chk({tag, ".valid"}, 32'(rd_valid), 32'(re));
        chk({tag, ".data"}, 32'(rd_data), 32'(last_rd));
    endtask

    // March C- over the model array: element 0 writes zeros, then r/w pairs.
    task automatic march_model(input logic [7:0] m, output bit fail, output int fa,
                               output int fe, output int cnt);
        logic [7:0] expv;
        int a;
        fail = 0; fa = 0; fe = 0; cnt = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        for (int e = 1; e <= 5; e++) begin
            expv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                a = (e == 3 || e == 4) ? (DEPTH - 1 - i) : i;
                if ((mem_m[a] ^ m) != expv) begin
                    if (cnt < 255) cnt++;
                    if (!fail) begin fail = 1; fa = a; fe = e; end
                end
                if (e != 5) mem_m[a] = ~expv;
            end
        end
    endtask

    task automatic run_bist(input bit ie, input logic [7:0] m, input bit repulse,
                            input bit fwr, input string tag);
        bit efail; int efa, efe, ecnt, n; bit vseen;
        march_model(ie ? m : 8'h00, efail, efa, efe, ecnt);
        inj_en = ie; inj_mask = m;
        bist_start = 1;
        tick();
        bist_start = 0;
        chk({tag, ".start_busy"}, 32'(bist_busy), 1);
        chk({tag, ".start_done"}, 32'(bist_done), 0);
        chk({tag, ".start_fail"}, 32'(bist_fail), 0);
        chk({tag, ".start_cnt"}, 32'(bist_err_cnt), 0);
        n = 0; vseen = 0;
        while (!bist_done && n < 400) begin
            if (repulse) bist_start = (n == 20 || n == 90);
            if (fwr) begin
                wr_en = $urandom_range(0, 1); rd_en = $urandom_range(0, 1);
                addr = 4'($urandom); wr_data = 8'($urandom);
            end
            tick();
            n++;
            bist_start = 0;
            if (rd_valid) vseen = 1;
        end
        wr_en = 0; rd_en = 0; inj_en = 0; inj_mask = 0;
        chk({tag, ".cycles"}, 32'(n), RUN_CYC);
        chk({tag, ".busy"}, 32'(bist_busy), 0);
        chk({tag, ".done"}, 32'(bist_done), 1);
        chk({tag, ".valid_during_run"}, 32'(vseen), 0);
        chk({tag, ".rd_hold"}, 32'(rd_data), 32'(last_rd));
        chk({tag, ".fail"}, 32'(bist_fail), 32'(efail));
        chk({tag, ".faddr"}, 32'(bist_fail_addr), 32'(efa));
        chk({tag, ".felem"}, 32'(bist_fail_elem), 32'(efe));
        chk({tag, ".errcnt"}, 32'(bist_err_cnt), 32'(ecnt));
        for (int i = 0; i < DEPTH; i++) op(0, 1, 4'(i), 8'h00, 0, 8'h00, {tag, ".readback"});
    endtask

    initial begin
        rst_n = 0; wr_en = 0; rd_en = 0; addr = 0; wr_data = 0;
        bist_start = 0; inj_en = 0; inj_mask = 0; last_rd = 0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        op(1, 0, 4'd3, 8'hA5, 0, 8'h00, "wr3");
        op(0, 1, 4'd3, 8'h00, 0, 8'h00, "rd3");
        op(0, 0, 4'd0, 8'h00, 0, 8'h00, "hold3");
        chk("bist_idle_busy", 32'(bist_busy), 0);
        chk("bist_idle_done", 32'(bist_done), 0);

        op(1, 0, 4'd5, 8'h11, 0, 8'h00, "wr5");
        op(1, 1, 4'd5, 8'h22, 0, 8'h00, "rbw5");
        op(0, 1, 4'd5, 8'h00, 0, 8'h00, "rd5");

        for (int i = 0; i < DEPTH; i++) op(1, 0, 4'(i), 8'($urandom), 0, 8'h00, "init");
        for (int k = 0; k < 150; k++) begin
            int kind;
            kind = $urandom_range(0, 3);
            op(kind != 1, kind != 0, 4'($urandom), 8'($urandom),
               $urandom_range(0, 3) == 0, 8'($urandom), "rand_op");
        end

        run_bist(0, 8'h00, 0, 0, "bist_clean");
        run_bist(1, 8'h01, 0, 0, "bist_inj01");
        run_bist(1, 8'($urandom_range(1, 255)), 0, 0, "bist_injrand");
        run_bist(0, 8'h00, 0, 0, "bist_rerun");

        // Reset mid-run aborts everything immediately.
        bist_start = 1;
        tick();
        bist_start = 0;
        repeat (50) tick();
        chk("abort_busy_before", 32'(bist_busy), 1);
        rst_n = 0;
        #1;
        chk_all_zero("abort");
        last_rd = 0;
        @(negedge clk);
        rst_n = 1;
        run_bist(0, 8'h00, 0, 0, "bist_after_abort");

        run_bist(0, 8'h00, 1, 1, "bist_disturb");
        run_bist(1, 8'h80, 1, 1, "bist_disturb_inj");

        for (int k = 0; k < 40; k++)
            op($urandom_range(0, 1), 1, 4'($urandom), 8'($urandom), 0, 8'h00, "post_op");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bist_march_ram.md
Name: bist_march_ram

Overview:
Parametrised single-port synchronous RAM with separate write and read data buses and a registered read. It embeds a March C- BIST engine that takes over the array on request and reports pass/fail, the first failing address and element, and an error count. A read-path fault-injection mask lets benches and silicon bring-up exercise the fail path. It is the next-generation memory macro for the BIST area and replaces ad-hoc tristate RAM instances.

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
ERRC_W, 8, width of the saturating BIST error counter

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  functional write strobe
rd_en  in  1  functional read strobe
addr  in  ADDR_W  functional address
wr_data  in  DATA_W  functional write data
rd_data  out  DATA_W  registered read data
rd_valid  out  1  high for 1 cycle when rd_data is updated
bist_start  in  1  start pulse; sampled only when idle
bist_busy  out  1  BIST owns the array
bist_done  out  1  level; test finished, results valid until the next start
bist_fail  out  1  sticky; at least one mismatch in the current run
bist_fail_addr  out  ADDR_W  address of the first mismatch
bist_fail_elem  out  3  March element index (0..5) of the first mismatch
bist_err_cnt  out  ERRC_W  mismatch count, saturating at all-ones
inj_en  in  1  enable read-path fault injection
inj_mask  in  DATA_W  XOR mask applied to array read data when inj_en=1

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM to IDLE. Array contents are not reset.
- Functional port (active only when bist_busy=0):
  - wr_en=1 writes wr_data to mem[addr] at the edge.
  - rd_en=1 at edge k gives rd_data = mem[addr] ^ (inj_en ? inj_mask : 0) and rd_valid=1 after edge k. Latency is 1 cycle.
  - rd_data holds between reads.
  - wr_en and rd_en together at the same address read old data (read-before-write).
- While bist_busy=1: wr_en and rd_en are ignored, rd_valid=0, rd_data holds.
- BIST FSM states: IDLE, W0, RD, CHK, DONE.
  - Elements: 0: up(w0); 1: up(r0,w1); 2: up(r1,w0); 3: down(r0,w1); 4: down(r1,w0); 5: up(r0). Here 0 means all-zeros and 1 means all-ones.
  - Up order is 0 to DEPTH-1; down order is DEPTH-1 to 0.
  - W0 (element 0): one write per cycle.
  - Elements 1-5, per address: RD issues the read, then CHK compares (array data ^ injection) against the expected value. In CHK, elements 1-4 also write the new value; element 5 does not write.
  - Total run = DEPTH + 10*DEPTH = 11*DEPTH cycles.
- Start and finish timing:
  - bist_start=1 in IDLE or DONE at edge k: bist_busy=1 and bist_done=0 from edge k; fail, fail_addr, fail_elem and err_cnt clear at edge k.
  - Finish: at edge k+11*DEPTH, bist_busy=0 and bist_done=1; the FSM goes to DONE.
  - bist_start while busy is ignored.
- Mismatch in CHK:
  - err_cnt increments, saturating.
  - On the first mismatch of the run only, fail_addr and fail_elem latch and bist_fail sets.
  - The run always completes.
- Address counter wraps internally at element boundaries only; there is no out-of-range access.
- Array contents after a passing run: all zeros.
- rst_n asserted mid-run aborts the run: all outputs 0, FSM in IDLE, array contents undefined.
- inj_en/inj_mask are sampled combinationally in the read path every cycle.

Test Plan:
- Reset, write mem[3]=0xA5, then read addr 3 -> rd_data=0xA5 and rd_valid=1 exactly 1 cycle after rd_en; all BIST outputs 0.
- Same-cycle wr_en+rd_en at addr 5 (old 0x11, new 0x22) -> rd_data=0x11; the next read returns 0x22.
- bist_start with inj_en=0, DEPTH=16 -> busy for exactly 176 cycles; done=1, fail=0, err_cnt=0; functional reads afterwards return 0x00.
- inj_en=1, inj_mask=0x01 for the whole run -> fail=1, fail_addr=0, fail_elem=1, err_cnt=80 (5 elements x 16).
- Pulse rst_n low at cycle 50 of a run -> all outputs 0 immediately; a new start then completes normally in 176 cycles.
- bist_start re-pulsed while busy -> ignored; completion still at 176 cycles; functional wr_en during the run does not alter the result.
